rangefinder_sopc_cpu_mul_seq: RTL and testbench

Multiply sequencer that sits directly upstream of the CPU 32x32 low-word multiply cell. It drives the cell's operands and consumes its registered result.
- MUL (low 32 bits): issues a single pass.
- MULXUU/MULXSS/MULXSU (high 32 bits): runs four 16x16 partial-product passes through the same cell, accumulates 64 bits, then applies the signed correction.
- Sits between the CPU execute stage (request/response handshake) and the mult cell instance.

---
 rtl/rangefinder_sopc_cpu_mul_pkg.sv | 33 +++
 rtl/rangefinder_sopc_cpu_mul_operand_sel.sv | 44 ++++
 rtl/rangefinder_sopc_cpu_mul_seq.sv | 143 ++++++++++++++
 tb/tb_rangefinder_sopc_cpu_mul_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rangefinder_sopc_cpu_mul_pkg.sv
// Shared definitions for the multiply sequencer: op codes, FSM states, partial-product shifts.
// No logic of its own; imported by the sequencer top and its operand selector.
// The partial-product order is fixed: lo*lo, lo*hi, hi*lo, hi*hi.
package rangefinder_sopc_cpu_mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSS = 2'b10;
  localparam logic [1:0] OP_MULXSU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    FIX  = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [5:0] PP_SHIFT_P0 = 6'd0;
  localparam logic [5:0] PP_SHIFT_P1 = 6'd16;
  localparam logic [5:0] PP_SHIFT_P2 = 6'd16;
  localparam logic [5:0] PP_SHIFT_P3 = 6'd32;

  // Accumulate shift for a given partial-product pass.
  function automatic logic [5:0] pp_shift(input logic [1:0] pass);
    case (pass)
      2'd0:    pp_shift = PP_SHIFT_P0;
      2'd1:    pp_shift = PP_SHIFT_P1;
      2'd2:    pp_shift = PP_SHIFT_P2;
      default: pp_shift = PP_SHIFT_P3;
    endcase
  endfunction

endpackage

// File: rtl/rangefinder_sopc_cpu_mul_operand_sel.sv
// Maps (op, pass, a, b) to the mult-cell operands and the accumulate shift for that pass.
// Purely combinational, zero latency.
// No flow control; the caller decides when the operands are actually driven.
module rangefinder_sopc_cpu_mul_operand_sel
  import rangefinder_sopc_cpu_mul_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [1:0]  pass_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] src1_o,
  output logic [31:0] src2_o,
  output logic [5:0]  shift_o
);

  // MUL uses the full operands; high ops feed 16-bit halves so the 32-bit cell result is exact.
  always_comb begin
    src1_o  = a_i;
    src2_o  = b_i;
    shift_o = 6'd0;
    if (op_i != OP_MUL) begin
      shift_o = pp_shift(pass_i);
      case (pass_i)
        2'd0: begin
          src1_o = {16'h0000, a_i[15:0]};
          src2_o = {16'h0000, b_i[15:0]};
        end
        2'd1: begin
          src1_o = {16'h0000, a_i[15:0]};
          src2_o = {16'h0000, b_i[31:16]};
        end
        2'd2: begin
          src1_o = {16'h0000, a_i[31:16]};
          src2_o = {16'h0000, b_i[15:0]};
        end
        default: begin
          src1_o = {16'h0000, a_i[31:16]};
          src2_o = {16'h0000, b_i[31:16]};
        end
      endcase
    end
  end

endmodule

// File: rtl/rangefinder_sopc_cpu_mul_seq.sv
// Multiply sequencer in front of the 32x32 low-word mult cell: MUL in one pass, MULX* in four 16x16 passes plus sign fix.
// Latency accept->rsp_valid: MUL CELL_LATENCY+2 cycles, high ops 4*(CELL_LATENCY+1)+2 cycles.
// One request in flight: req_ready only in IDLE; the response is held until rsp_ready.
module rangefinder_sopc_cpu_mul_seq
  import rangefinder_sopc_cpu_mul_pkg::*;
#(
  parameter int unsigned CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic [31:0] A_mul_src1,
  output logic [31:0] A_mul_src2,
  input  logic [31:0] A_mul_cell_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy
);

  localparam int unsigned CNT_W = (CELL_LATENCY > 1) ? 2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_LATENCY);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [1:0]        pass_q, pass_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       acc_q, acc_d;
  logic [31:0]       rsp_q, rsp_d;

  logic [31:0] sel_src1, sel_src2;
  logic [5:0]  sel_shift;
  logic [63:0] pp_ext;
  logic [31:0] corr_a, corr_b;
  logic [31:0] fix_hi;

  rangefinder_sopc_cpu_mul_operand_sel u_operand_sel (
    .op_i    (op_q),
    .pass_i  (pass_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .src1_o  (sel_src1),
    .src2_o  (sel_src2),
    .shift_o (sel_shift)
  );

  assign pp_ext = {32'h0000_0000, A_mul_cell_result} << sel_shift;

  // Two's-complement correction of the unsigned high word: subtract b if a is negative, a if b is negative.
  assign corr_a = ((op_q == OP_MULXSS || op_q == OP_MULXSU) && a_q[31]) ? b_q : 32'h0;
  assign corr_b = ((op_q == OP_MULXSS) && b_q[31]) ? a_q : 32'h0;
  assign fix_hi = acc_q[63:32] - corr_a - corr_b;

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_data   = rsp_q;
  assign A_mul_src1 = (state_q == PASS) ? sel_src1 : 32'h0;
  assign A_mul_src2 = (state_q == PASS) ? sel_src2 : 32'h0;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      pass_q  <= 2'd0;
      cnt_q   <= '0;
      acc_q   <= 64'h0;
      rsp_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rsp_q   <= rsp_d;
    end
  end

  // Next-state: capture request, step passes with a settle counter, fix up the high word, hold response.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rsp_d   = rsp_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_src1;
          b_d     = req_src2;
          pass_d  = 2'd0;
          cnt_d   = '0;
          acc_d   = 64'h0;
          state_d = PASS;
        end
      end
      PASS: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (op_q == OP_MUL) begin
            rsp_d   = A_mul_cell_result;
            state_d = RESP;
          end else begin
            acc_d = acc_q + pp_ext;
            if (pass_q == 2'd3) begin
              state_d = FIX;
            end else begin
              pass_d = pass_q + 2'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        rsp_d   = fix_hi;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rangefinder_sopc_cpu_mul_seq.sv
// Bench for the multiply sequencer: two instances (cell latency 1 and 2), each fed by a behavioural mult cell.
// Vector table, hand sequences for backpressure and mid-operation reset, then random ops vs a 64-bit product model.
// All sampling and driving happens on the falling edge.
module tb_rangefinder_sopc_cpu_mul_seq;

  logic        clk;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [1:0]  req_op    [2];
  logic [31:0] req_src1  [2];
  logic [31:0] req_src2  [2];
  logic [31:0] mul_src1  [2];
  logic [31:0] mul_src2  [2];
  logic [31:0] cell_res  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        busy      [2];

  int checks = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gd
    logic [31:0] pipe [3];
    always @(posedge clk) begin
      pipe[0] <= mul_src1[g] * mul_src2[g];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign cell_res[g] = pipe[g];

    rangefinder_sopc_cpu_mul_seq #(.CELL_LATENCY(g + 1)) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid[g]),
      .req_ready         (req_ready[g]),
      .req_op            (req_op[g]),
      .req_src1          (req_src1[g]),
      .req_src2          (req_src2[g]),
      .A_mul_src1        (mul_src1[g]),
      .A_mul_src2        (mul_src2[g]),
      .A_mul_cell_result (cell_res[g]),
      .rsp_valid         (rsp_valid[g]),
      .rsp_ready         (rsp_ready[g]),
      .rsp_data          (rsp_data[g]),
      .busy              (busy[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: full 64-bit product of the (sign-extended) operands.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {32'h0, a};
    eb = {32'h0, b};
    if (op == 2'b10 || op == 2'b11) ea = {{32{a[31]}}, a};
    if (op == 2'b10) eb = {{32{b[31]}}, b};
    p = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int ref_lat(input int d, input logic [1:0] op);
    int lat_cell;
    lat_cell = d + 1;
    return (op == 2'b00) ? lat_cell + 2 : 4 * (lat_cell + 1) + 2;
  endfunction

  // Called at the falling edge of cycle 1 after accept; returns the first cycle with rsp_valid (0 on timeout).
  task automatic wait_rsp(input int d, input logic [31:0] o1, input logic [31:0] o2,
                          output logic [31:0] data, output int lat, output int nobs);
    int cyc;
    cyc = 1; lat = 0; nobs = 0; data = 32'h0;
    while (cyc < 60 && lat == 0) begin
      if (mul_src1[d] == o1 && mul_src2[d] == o2) nobs++;
      if (rsp_valid[d]) begin
        lat = cyc;
        data = rsp_data[d];
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (lat == 0) chk("rsp_timeout", 64'(lat), 64'(1));
  endtask

  task automatic issue(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_op[d]    = op;
    req_src1[d]  = a;
    req_src2[d]  = b;
    guard = 0;
    while (!req_ready[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready[d]) chk("accept_timeout", 64'(req_ready[d]), 64'(1));
    @(posedge clk);
    @(negedge clk);
    // Scramble the request inputs: the captured copy must be what gets used.
    req_valid[d] = 1'b0;
    req_op[d]    = 2'($urandom_range(0, 3));
    req_src1[d]  = $urandom;
    req_src2[d]  = $urandom;
  endtask

  task automatic run_op(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] o1, input logic [31:0] o2,
                        output logic [31:0] data, output int lat, output int nobs);
    rsp_ready[d] = 1'b1;
    issue(d, op, a, b);
    wait_rsp(d, o1, o2, data, lat, nobs);
    if (lat != 0) begin
      @(negedge clk);
      chk("rsp_valid_drop", 64'(rsp_valid[d]), 64'(0));
      chk("ready_after_rsp", 64'(req_ready[d]), 64'(1));
    end
  endtask

  typedef struct {
    int          d;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    int          exp_lat;
    logic [31:0] o1;
    logic [31:0] o2;
    int          exp_nobs;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] data, expd, a, b;
    int lat, nobs, cyc;
    logic [1:0] op;
    int d;

    vecs[0]  = '{0, 2'b00, 32'h7,        32'h6,        32'h0000002A, 3,  32'h7,    32'h6,    2};
    vecs[1]  = '{0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 10, 32'hFFFF, 32'hFFFF, 8};
    vecs[2]  = '{0, 2'b10, 32'h80000000, 32'h80000000, 32'h40000000, 10, 32'h1,    32'h1,    -1};
    vecs[3]  = '{0, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 10, 32'h1,    32'h1,    -1};
    vecs[4]  = '{0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 10, 32'h1,    32'h1,    -1};
    vecs[5]  = '{0, 2'b11, 32'h00000002, 32'h80000000, 32'h00000001, 10, 32'h2,    32'h8000, 2};
    vecs[6]  = '{1, 2'b00, 32'h7,        32'h6,        32'h0000002A, 4,  32'h7,    32'h6,    3};
    vecs[7]  = '{1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 14, 32'hFFFF, 32'hFFFF, 12};
    vecs[8]  = '{1, 2'b10, 32'h80000000, 32'h80000000, 32'h40000000, 14, 32'h1,    32'h1,    -1};
    vecs[9]  = '{0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 3,  32'h1,    32'h1,    -1};
    vecs[10] = '{1, 2'b11, 32'h00000002, 32'h80000000, 32'h00000001, 14, 32'h2,    32'h8000, 3};

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_op[i] = 2'b00; req_src1[i] = 32'h0; req_src2[i] = 32'h0;
      rsp_ready[i] = 1'b1;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", 64'(req_ready[i]), 64'(1));
      chk("rst_rsp_valid", 64'(rsp_valid[i]), 64'(0));
      chk("rst_rsp_data",  64'(rsp_data[i]),  64'(0));
      chk("rst_src",       {mul_src1[i], mul_src2[i]}, 64'h0);
      chk("rst_busy",      64'(busy[i]), 64'(0));
    end
    @(negedge clk);
    reset = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].d, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].o1, vecs[i].o2, data, lat, nobs);
      chk($sformatf("vec%0d_data", i), 64'(data), 64'(vecs[i].exp_data));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      if (vecs[i].exp_nobs >= 0) chk($sformatf("vec%0d_operand_cycles", i), 64'(nobs), 64'(vecs[i].exp_nobs));
    end

    // Backpressure: hold the response, offer a second request meanwhile.
    rsp_ready[0] = 1'b0;
    issue(0, 2'b01, 32'h12345678, 32'h9ABCDEF0);
    wait_rsp(0, 32'h1, 32'h1, data, lat, nobs);
    expd = ref_res(2'b01, 32'h12345678, 32'h9ABCDEF0);
    chk("bp_data", 64'(data), 64'(expd));
    req_valid[0] = 1'b1; req_op[0] = 2'b00; req_src1[0] = 32'd3; req_src2[0] = 32'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(rsp_valid[0]), 64'(1));
      chk("bp_hold_data",  64'(rsp_data[0]),  64'(expd));
      chk("bp_hold_ready", 64'(req_ready[0]), 64'(0));
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_after_hs_valid", 64'(rsp_valid[0]), 64'(0));
    chk("bp_after_hs_ready", 64'(req_ready[0]), 64'(1));
    @(negedge clk);
    chk("bp_second_accepted", 64'(busy[0]), 64'(1));
    req_valid[0] = 1'b0;
    wait_rsp(0, 32'h1, 32'h1, data, lat, nobs);
    chk("bp_second_data", 64'(data), 64'(15));
    chk("bp_second_lat",  64'(lat),  64'(3));
    @(negedge clk);

    // Reset during pass 2 of MULXUU, on each latency variant.
    for (int dd = 0; dd < 2; dd++) begin
      rsp_ready[dd] = 1'b1;
      issue(dd, 2'b01, 32'hABCD1234, 32'h56789ABC);
      for (int k = 0; k < 2 * (dd + 2); k++) @(negedge clk);
      chk("rstmid_pass2_src", {mul_src1[dd], mul_src2[dd]}, {32'h0000ABCD, 32'h00009ABC});
      #2 reset = 1'b1;
      #1;
      chk("rstmid_req_ready", 64'(req_ready[dd]), 64'(1));
      chk("rstmid_rsp_valid", 64'(rsp_valid[dd]), 64'(0));
      chk("rstmid_rsp_data",  64'(rsp_data[dd]),  64'(0));
      chk("rstmid_src",       {mul_src1[dd], mul_src2[dd]}, 64'h0);
      chk("rstmid_busy",      64'(busy[dd]), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      cyc = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (rsp_valid[dd]) cyc++;
      end
      chk("rstmid_no_rsp", 64'(cyc), 64'(0));
      run_op(dd, 2'b00, 32'd3, 32'd5, 32'd3, 32'd5, data, lat, nobs);
      chk("rstmid_next_data", 64'(data), 64'(15));
      chk("rstmid_next_lat",  64'(lat),  64'(ref_lat(dd, 2'b00)));
    end

    // Random operations against the 64-bit product model.
    for (int i = 0; i < 40; i++) begin
      d  = int'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: b = 32'hFFFFFFFF;
        2: a = {16'h0, a[15:0]};
        default: ;
      endcase
      run_op(d, op, a, b, 32'h1, 32'h1, data, lat, nobs);
      chk($sformatf("rand%0d_data op%0d a=%h b=%h", i, op, a, b), 64'(data), 64'(ref_res(op, a, b)));
      chk($sformatf("rand%0d_lat", i), 64'(lat), 64'(ref_lat(d, op)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
